// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the TX stream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic {
        stIdle = 1'b0,
        stXfer = 1'b1
    } state_e;

    localparam int cGrantW = 2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/tx_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_arbiter_if
// Brief    : Requester byte streams plus TX FIFO write port and status.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_stream_arbiter_if #(
    parameter int cNumReq = 2
);
    import uart_pkg::*;

    logic [cNumReq-1:0]   ReqValid;
    logic [8*cNumReq-1:0] ReqData;
    logic [cNumReq-1:0]   ReqLast;
    logic [cNumReq-1:0]   ReqReady;
    logic                 TxFfAfull;
    logic                 TxFfWrEn;
    logic [7:0]           TxFfWrData;
    logic                 Busy;
    logic [cGrantW-1:0]   GrantId;
    logic                 LenErr;

    // Environment side: requesters and the FIFO almost-full flag.
    modport master (
        output ReqValid, ReqData, ReqLast, TxFfAfull,
        input  ReqReady, TxFfWrEn, TxFfWrData, Busy, GrantId, LenErr
    );

    // Arbiter side.
    modport slave (
        input  ReqValid, ReqData, ReqLast, TxFfAfull,
        output ReqReady, TxFfWrEn, TxFfWrData, Busy, GrantId, LenErr
    );

endinterface : tx_stream_arbiter_if
`default_nettype wire

// File: rtl/tx_stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: rotate, priority encode, unrotate.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int cNumReq = 2
) (
    input  logic [cNumReq-1:0] i_req,
    input  logic [cGrantW-1:0] i_ptr,
    output logic [cGrantW-1:0] o_winner,
    output logic               o_any
);

    logic [cNumReq-1:0] w_rot;
    int                 w_off;
    int                 w_sum;

    // w_rot[k] is the requester k+1 places after the last grant.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < cNumReq; k++) begin
            for (int j = 0; j < cNumReq; j++) begin
                if (((int'(i_ptr) + 1 + k) % cNumReq) == j) begin
                    w_rot[k] = i_req[j];
                end
            end
        end
    end

    always_comb begin
        w_off = 0;
        for (int k = cNumReq - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        w_sum    = (int'(i_ptr) + 1 + w_off) % cNumReq;
        o_winner = cGrantW'(w_sum);
        o_any    = |i_req;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_arbiter
// Brief    : Packet-granular round-robin arbiter feeding the UART TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tx_stream_arbiter
    import uart_pkg::*;
#(
    parameter int cNumReq = 2,
    parameter int cMaxLen = 64
) (
    input  logic                Clk,
    input  logic                RstB,
    tx_stream_arbiter_if.slave  bus
);

    localparam logic [cGrantW-1:0] cPtrRst = cGrantW'(cNumReq - 1);
    localparam logic [7:0]         cLenCap = 8'(cMaxLen - 1);

    state_e              state_q, state_d;
    logic [cGrantW-1:0]  grant_q, grant_d;
    logic [cGrantW-1:0]  ptr_q, ptr_d;
    logic [7:0]          len_q, len_d;
    logic                wr_en_q, wr_en_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                len_err_q, len_err_d;

    logic [cGrantW-1:0]  w_winner;
    logic                w_any;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [7:0]          w_sel_data;
    logic                w_accept;
    logic                w_cap_hit;
    logic [cNumReq-1:0]  w_ready;

    rr_pick #(
        .cNumReq (cNumReq)
    ) u_pick (
        .i_req    (bus.ReqValid),
        .i_ptr    (ptr_q),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Mux the granted requester's lane.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < cNumReq; i++) begin
            if (grant_q == cGrantW'(i)) begin
                w_sel_valid = bus.ReqValid[i];
                w_sel_last  = bus.ReqLast[i];
                w_sel_data  = bus.ReqData[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        len_err_d = 1'b0;
        w_ready   = '0;
        w_accept  = 1'b0;
        w_cap_hit = (len_q == cLenCap);

        case (state_q)
            stIdle: begin
                if (w_any) begin
                    grant_d = w_winner;
                    len_d   = 8'h00;
                    state_d = stXfer;
                end
            end
            stXfer: begin
                for (int i = 0; i < cNumReq; i++) begin
                    if (grant_q == cGrantW'(i)) begin
                        w_ready[i] = !bus.TxFfAfull;
                    end
                end
                w_accept = w_sel_valid && !bus.TxFfAfull;
                if (w_accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = w_sel_data;
                    len_d     = len_q + 8'd1;
                    // A cap-cut packet releases the grant; the tail re-arbitrates.
                    if (w_sel_last || w_cap_hit) begin
                        ptr_d     = grant_q;
                        state_d   = stIdle;
                        len_err_d = !w_sel_last;
                    end
                end
            end
            default: begin
                state_d = stIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RstB) begin
            state_q   <= stIdle;
            grant_q   <= '0;
            ptr_q     <= cPtrRst;
            len_q     <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'h00;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.ReqReady   = w_ready;
    assign bus.TxFfWrEn   = wr_en_q;
    assign bus.TxFfWrData = wr_data_q;
    assign bus.Busy       = (state_q == stXfer);
    assign bus.GrantId    = grant_q;
    assign bus.LenErr     = len_err_q;

endmodule : tx_stream_arbiter
`default_nettype wire

// File: tb/tb_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_stream_arbiter
// Brief    : Directed vector bench for tx_stream_arbiter (2 requesters, cap 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_stream_arbiter;

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] last;
        logic       af;
        logic [1:0] rdy;
        logic       wen;
        logic [7:0] wd;
        logic       busy;
        logic [1:0] gid;
        logic       lerr;
    } vec_t;

    logic Clk  = 1'b0;
    logic RstB = 1'b1;
    int   total = 0;
    int   bad   = 0;

    tx_stream_arbiter_if #(.cNumReq(2)) bus ();

    tx_stream_arbiter #(
        .cNumReq (2),
        .cMaxLen (4)
    ) dut (
        .Clk  (Clk),
        .RstB (RstB),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(
        input logic rst, input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
        input logic [1:0] last, input logic af, input logic [1:0] rdy, input logic wen,
        input logic [7:0] wd, input logic busy, input logic [1:0] gid, input logic lerr);
        vec_t t;
        t.rst = rst; t.v = v; t.d0 = d0; t.d1 = d1; t.last = last; t.af = af;
        t.rdy = rdy; t.wen = wen; t.wd = wd; t.busy = busy; t.gid = gid; t.lerr = lerr;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational ready, then the registered outputs.
    task automatic apply(input string tag, input int row, input vec_t t);
        RstB          = t.rst;
        bus.ReqValid  = t.v;
        bus.ReqData   = {t.d1, t.d0};
        bus.ReqLast   = t.last;
        bus.TxFfAfull = t.af;
        #1;
        chk({tag, "_ready"}, row, {6'd0, bus.ReqReady}, {6'd0, t.rdy});
        @(posedge Clk);
        #1;
        chk({tag, "_wren"},   row, {7'd0, bus.TxFfWrEn}, {7'd0, t.wen});
        chk({tag, "_wrdata"}, row, bus.TxFfWrData, t.wd);
        chk({tag, "_busy"},   row, {7'd0, bus.Busy}, {7'd0, t.busy});
        chk({tag, "_gid"},    row, {6'd0, bus.GrantId}, {6'd0, t.gid});
        chk({tag, "_lenerr"}, row, {7'd0, bus.LenErr}, {7'd0, t.lerr});
    endtask

    task automatic do_reset();
        RstB          = 1'b1;
        bus.ReqValid  = 2'b00;
        bus.ReqData   = 16'h0000;
        bus.ReqLast   = 2'b00;
        bus.TxFfAfull = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        RstB = 1'b0;
    endtask

    vec_t ta[24];
    vec_t tc[10];
    logic [7:0] cont_exp[8];

    initial begin
        // Single packet, backpressure, then length cap (cMaxLen = 4).
        ta[0]  = mk(0, 2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 1, 2'd0, 0);
        ta[1]  = mk(0, 2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b01, 1, 8'h41, 1, 2'd0, 0);
        ta[2]  = mk(0, 2'b01, 8'h42, 8'h00, 2'b00, 0, 2'b01, 1, 8'h42, 1, 2'd0, 0);
        ta[3]  = mk(0, 2'b01, 8'h43, 8'h00, 2'b01, 0, 2'b01, 1, 8'h43, 0, 2'd0, 0);
        ta[4]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h43, 0, 2'd0, 0);
        ta[5]  = mk(0, 2'b01, 8'h51, 8'h00, 2'b00, 0, 2'b00, 0, 8'h43, 1, 2'd0, 0);
        ta[6]  = mk(0, 2'b01, 8'h51, 8'h00, 2'b00, 0, 2'b01, 1, 8'h51, 1, 2'd0, 0);
        for (int i = 7; i < 12; i++)
            ta[i] = mk(0, 2'b01, 8'h52, 8'h00, 2'b00, 1, 2'b00, 0, 8'h51, 1, 2'd0, 0);
        ta[12] = mk(0, 2'b01, 8'h52, 8'h00, 2'b00, 0, 2'b01, 1, 8'h52, 1, 2'd0, 0);
        ta[13] = mk(0, 2'b01, 8'h53, 8'h00, 2'b01, 0, 2'b01, 1, 8'h53, 0, 2'd0, 0);
        ta[14] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h53, 0, 2'd0, 0);
        ta[15] = mk(0, 2'b10, 8'h00, 8'h61, 2'b00, 0, 2'b00, 0, 8'h53, 1, 2'd1, 0);
        ta[16] = mk(0, 2'b10, 8'h00, 8'h61, 2'b00, 0, 2'b10, 1, 8'h61, 1, 2'd1, 0);
        ta[17] = mk(0, 2'b10, 8'h00, 8'h62, 2'b00, 0, 2'b10, 1, 8'h62, 1, 2'd1, 0);
        ta[18] = mk(0, 2'b10, 8'h00, 8'h63, 2'b00, 0, 2'b10, 1, 8'h63, 1, 2'd1, 0);
        ta[19] = mk(0, 2'b10, 8'h00, 8'h64, 2'b00, 0, 2'b10, 1, 8'h64, 0, 2'd1, 1);
        ta[20] = mk(0, 2'b10, 8'h00, 8'h65, 2'b00, 0, 2'b00, 0, 8'h64, 1, 2'd1, 0);
        ta[21] = mk(0, 2'b10, 8'h00, 8'h65, 2'b00, 0, 2'b10, 1, 8'h65, 1, 2'd1, 0);
        ta[22] = mk(0, 2'b10, 8'h00, 8'h66, 2'b10, 0, 2'b10, 1, 8'h66, 0, 2'd1, 0);
        ta[23] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h66, 0, 2'd1, 0);

        // Reset in the middle of a requester-1 packet, then requester 0 must win.
        tc[0] = mk(0, 2'b01, 8'h11, 8'h00, 2'b01, 0, 2'b00, 0, 8'h00, 1, 2'd0, 0);
        tc[1] = mk(0, 2'b01, 8'h11, 8'h00, 2'b01, 0, 2'b01, 1, 8'h11, 0, 2'd0, 0);
        tc[2] = mk(0, 2'b10, 8'h00, 8'h21, 2'b00, 0, 2'b00, 0, 8'h11, 1, 2'd1, 0);
        tc[3] = mk(0, 2'b10, 8'h00, 8'h21, 2'b00, 0, 2'b10, 1, 8'h21, 1, 2'd1, 0);
        tc[4] = mk(0, 2'b10, 8'h00, 8'h22, 2'b00, 0, 2'b10, 1, 8'h22, 1, 2'd1, 0);
        tc[5] = mk(1, 2'b11, 8'h31, 8'h23, 2'b00, 0, 2'b10, 0, 8'h00, 0, 2'd0, 0);
        tc[6] = mk(0, 2'b11, 8'h31, 8'h23, 2'b00, 0, 2'b00, 0, 8'h00, 1, 2'd0, 0);
        tc[7] = mk(0, 2'b11, 8'h31, 8'h23, 2'b00, 0, 2'b01, 1, 8'h31, 1, 2'd0, 0);
        tc[8] = mk(0, 2'b11, 8'h32, 8'h23, 2'b01, 0, 2'b01, 1, 8'h32, 0, 2'd0, 0);
        tc[9] = mk(0, 2'b10, 8'h00, 8'h23, 2'b00, 0, 2'b00, 0, 8'h32, 1, 2'd1, 0);

        cont_exp = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h02, 8'h03, 8'h82, 8'h83};

        do_reset();
        chk("rst_ready",  0, {6'd0, bus.ReqReady}, 8'h00);
        chk("rst_wren",   0, {7'd0, bus.TxFfWrEn}, 8'h00);
        chk("rst_wrdata", 0, bus.TxFfWrData, 8'h00);
        chk("rst_busy",   0, {7'd0, bus.Busy}, 8'h00);
        chk("rst_gid",    0, {6'd0, bus.GrantId}, 8'h00);
        chk("rst_lenerr", 0, {7'd0, bus.LenErr}, 8'h00);

        for (int i = 0; i < 24; i++) apply("tbl", i, ta[i]);

        // Contention: both requesters stream 2-byte packets; grants alternate 0,1,0,1.
        do_reset();
        begin
            int  cnt0 = 0;
            int  cnt1 = 0;
            int  nwr  = 0;
            logic acc0, acc1;
            for (int cyc = 0; cyc < 40 && nwr < 8; cyc++) begin
                bus.ReqValid = 2'b11;
                bus.ReqData  = {8'(8'h80 + cnt1), 8'(cnt0)};
                bus.ReqLast  = {cnt1[0], cnt0[0]};
                #1;
                acc0 = bus.ReqReady[0];
                acc1 = bus.ReqReady[1];
                @(posedge Clk);
                #1;
                if (acc0) cnt0++;
                if (acc1) cnt1++;
                if (bus.TxFfWrEn) begin
                    chk("cont_data", nwr, bus.TxFfWrData, cont_exp[nwr]);
                    chk("cont_gid",  nwr, {6'd0, bus.GrantId}, 8'((nwr / 2) % 2));
                    nwr++;
                end
            end
            chk("cont_timeout", nwr, 8'(nwr), 8'd8);
        end

        do_reset();
        for (int i = 0; i < 10; i++) apply("rstmid", i, tc[i]);

        // Idle stall: granted requester 0 pauses 10 cycles while requester 1 waits.
        do_reset();
        apply("stall", 0, mk(0, 2'b01, 8'hA1, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 1, 2'd0, 0));
        apply("stall", 1, mk(0, 2'b11, 8'hA1, 8'hB1, 2'b00, 0, 2'b01, 1, 8'hA1, 1, 2'd0, 0));
        for (int i = 2; i < 12; i++)
            apply("stall", i, mk(0, 2'b10, 8'h00, 8'hB1, 2'b00, 0, 2'b01, 0, 8'hA1, 1, 2'd0, 0));
        apply("stall", 12, mk(0, 2'b11, 8'hA2, 8'hB1, 2'b01, 0, 2'b01, 1, 8'hA2, 0, 2'd0, 0));
        apply("stall", 13, mk(0, 2'b10, 8'h00, 8'hB1, 2'b10, 0, 2'b00, 0, 8'hA2, 1, 2'd1, 0));
        apply("stall", 14, mk(0, 2'b10, 8'h00, 8'hB1, 2'b10, 0, 2'b10, 1, 8'hB1, 0, 2'd1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tx_stream_arbiter
`default_nettype wire

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Round-robin arbiter that shares the single UART transmit FIFO between up to four byte-stream requesters. Each requester sends whole packets. A packet is a run of bytes ending with a byte flagged last. The arbiter grants one requester at a time, holds the grant until that packet ends, and writes the granted bytes into the TX FIFO write port. The TX serializer drains the FIFO on its read side, so the arbiter is the only writer to that FIFO.

## Interface
Parameters:
- cNumReq, 2: number of requesters; legal range 2..4.
- cMaxLen, 64: maximum packet length in bytes; legal range 2..255.

Ports:
- Clk  in  1  single clock.
- RstB  in  1  synchronous reset, active-high (the name is historical; it is not active-low).
- ReqValid  in  cNumReq  per-requester byte valid.
- ReqData  in  8*cNumReq  per-requester byte; requester i drives bits [8i+7:8i].
- ReqLast  in  cNumReq  per-requester flag: current byte is the last of its packet.
- ReqReady  out  cNumReq  per-requester accept; combinational.
- TxFfAfull  in  1  FIFO almost-full; asserted when the FIFO has at most 1 free entry.
- TxFfWrEn  out  1  FIFO write strobe; registered.
- TxFfWrData  out  8  FIFO write data; registered.
- Busy  out  1  high while a grant is held; registered.
- GrantId  out  2  index of the granted requester; valid while Busy.
- LenErr  out  1  one-cycle pulse when a packet is cut at cMaxLen; registered.

## Operation
- State machine with states stIdle and stXfer. rGrant holds the granted index. rPtr holds the index granted last.
- stIdle:
  - If any ReqValid is high, grant the first requester with ReqValid high, searching rPtr+1, rPtr+2, … modulo cNumReq.
  - Register the result into rGrant, clear rLen, go to stXfer.
  - No bytes are accepted in stIdle.
- stXfer:
  - ReqReady[rGrant] = !TxFfAfull. All other ReqReady bits are 0.
  - A beat is accepted when ReqValid[rGrant] and ReqReady[rGrant] are both high.
  - On each accepted beat, rLen increments (8-bit counter, no wrap is possible).
- Packet end, on an accepted beat:
  - If ReqLast is high, or rLen == cMaxLen-1 (this beat is byte number cMaxLen): rPtr <= rGrant, then go to stIdle.
  - If the end came from the length cap and ReqLast is low, pulse LenErr. The requester's remaining bytes are arbitrated later as a new packet.
- Grant retention: while in stXfer, ReqValid[rGrant] low just stalls. The grant is held indefinitely. No timeout.
- Write path: an accepted beat drives TxFfWrEn=1 and TxFfWrData=that byte on the next cycle. Otherwise TxFfWrEn=0 and TxFfWrData holds its value.
- Busy = (state == stXfer). GrantId = rGrant, zero-extended to 2 bits.
- Reset values:
  - State = stIdle; rPtr = cNumReq-1, so requester 0 wins first.
  - rGrant = 0, rLen = 0.
  - TxFfWrEn = 0, TxFfWrData = 8'h00, Busy = 0, LenErr = 0, ReqReady = 0.
- Reset in mid-packet: the current grant is abandoned, with no pending write and no LenErr. The next stIdle arbitration treats the requester's following byte as a packet start.

## Timing
- Arbitration latency: ReqValid rising in stIdle at cycle t → grant registered at t+1 → first beat can be accepted at t+1 → TxFfWrEn at t+2.
- Sustained throughput: 1 byte per cycle while ReqValid is high and TxFfAfull is low.
- Last beat accepted at cycle t → stIdle at t+1 → next grant at t+2. Gap between packets is 1 cycle.
- Backpressure: TxFfAfull covers the one write still in flight from the registered write stage, so the FIFO never overflows.
- ReqValid is sampled only in stIdle for arbitration. Requesters must hold ReqValid, ReqData and ReqLast stable until accepted.

## Structure
- Shared package uart_pkg:
  - state encoding, stIdle = 1'b0 and stXfer = 1'b1;
  - the GrantId width constant, 2.
- Sub-module rr_pick (combinational):
  - inputs: request vector and rPtr;
  - outputs: winner index and any-request flag;
  - built as a rotate, then priority encode, then add rPtr+1 modulo cNumReq.
- Everything else is written inline.

## Test plan
- Single requester: req0 sends 3 bytes 8'h41, 8'h42, 8'h43 (last on 8'h43).
  - TxFfWrEn high for 3 consecutive cycles starting 2 cycles after ReqValid.
  - Data in order; Busy drops the cycle after the last beat.
- Contention: req0 and req1 both valid from reset, each sending 2-byte packets repeatedly.
  - Grants alternate 0, 1, 0, 1.
  - Bytes of different packets are never interleaved.
- Backpressure: assert TxFfAfull for 5 cycles in the middle of a packet.
  - ReqReady and TxFfWrEn are 0 during those cycles (TxFfWrEn lags by 1).
  - No byte is lost or duplicated.
- Length cap: with cMaxLen=4, req1 sends 6 bytes with last on the 6th.
  - LenErr pulses once, after the 4th byte.
  - The remaining 2 bytes go out as a separate grant.
- Reset in mid-packet: assert RstB after byte 2 of 5.
  - All outputs return to their reset values the next cycle.
  - Req0 wins the first grant after reset.
- Idle stall: granted requester drops ReqValid for 10 cycles while another requester is valid.
  - The grant is retained; the other requester waits.
